// File: rtl/muldiv_seq_ctrl.sv
// EX-stage sequencer between the pipeline and the iterative mul/div unit; owns HI/LO.
// Optional macro MULDIV_SEQ_FWD_EN: accept MFLO/MFHI in the unit's done cycle and forward its result.
module muldiv_seq_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic        req_ready_o,
  output logic        stall_o,
  output logic [31:0] res_o,
  output logic        res_valid_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        unit_start_o,
  output logic        unit_div_o,
  output logic [31:0] unit_a_o,
  output logic [31:0] unit_b_o,
  output logic        unit_abort_o,
  input  logic        unit_done_i,
  input  logic [31:0] unit_hi_i,
  input  logic [31:0] unit_lo_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2
  } state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;

  state_t           r_state;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic w_fwd;
  logic w_accept;
  logic w_expire;
  logic w_div_zero;

  // Handshake: a request transfers on a cycle where req_valid_i and req_ready_o are both high;
  // the requester holds op/operands stable until then, and stall_o marks the waiting cycles.
`ifdef MULDIV_SEQ_FWD_EN
  assign w_fwd = (r_state == S_BUSY) & unit_done_i & req_valid_i & req_op_i[1];
`else
  assign w_fwd = 1'b0;
`endif

  assign req_ready_o = (r_state == S_IDLE) | w_fwd;
  assign stall_o     = req_valid_i & ~req_ready_o;
  assign w_accept    = req_valid_i & req_ready_o;
  assign w_expire    = (r_cnt == CNT_W'(MAX_CYCLES - 1));
  assign w_div_zero  = (req_op_i == OP_DIV) && (req_b_i == 32'd0);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_hi         <= 32'd0;
      r_lo         <= 32'd0;
      r_cnt        <= '0;
      res_o        <= 32'd0;
      res_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
      unit_start_o <= 1'b0;
      unit_div_o   <= 1'b0;
      unit_a_o     <= 32'd0;
      unit_b_o     <= 32'd0;
      unit_abort_o <= 1'b0;
    end else begin
      unit_start_o <= 1'b0;
      unit_abort_o <= 1'b0;
      res_valid_o  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (req_op_i == OP_MULT || req_op_i == OP_DIV) begin
              // Divide-by-zero never reaches the unit: quotient all-ones, remainder = dividend.
              if (w_div_zero) begin
                r_hi <= req_a_i;
                r_lo <= 32'hFFFF_FFFF;
              end else begin
                unit_a_o     <= req_a_i;
                unit_b_o     <= req_b_i;
                unit_div_o   <= req_op_i[0];
                unit_start_o <= 1'b1;
                busy_o       <= 1'b1;
                r_state      <= S_LAUNCH;
              end
            end else begin
              res_o       <= req_op_i[0] ? r_hi : r_lo;
              res_valid_o <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Done takes priority over watchdog expiry in the same cycle.
          if (unit_done_i) begin
            r_hi    <= unit_hi_i;
            r_lo    <= unit_lo_i;
            busy_o  <= 1'b0;
            r_state <= S_IDLE;
            if (w_fwd) begin
              res_o       <= req_op_i[0] ? unit_hi_i : unit_lo_i;
              res_valid_o <= 1'b1;
            end
          end else if (w_expire) begin
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            timeout_o    <= 1'b1;
            unit_abort_o <= 1'b1;
            busy_o       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: the bench also plays the mul/div unit,
// and a HI/LO model plus an expected-result queue predict every read.
`timescale 1ns/1ps
module tb_muldiv_seq_ctrl;

  localparam int MAX_CYCLES = 40;
`ifdef MULDIV_SEQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // clock / reset
  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        req_valid_i = 1'b0;
  logic [1:0]  req_op_i    = 2'b00;
  logic [31:0] req_a_i     = 32'd0;
  logic [31:0] req_b_i     = 32'd0;
  logic        req_ready_o;
  logic        stall_o;
  logic [31:0] res_o;
  logic        res_valid_o;
  logic        busy_o;
  logic        timeout_o;
  logic        unit_start_o;
  logic        unit_div_o;
  logic [31:0] unit_a_o;
  logic [31:0] unit_b_o;
  logic        unit_abort_o;
  logic        unit_done_i = 1'b0;
  logic [31:0] unit_hi_i   = 32'd0;
  logic [31:0] unit_lo_i   = 32'd0;
  logic [1:0]  dbg_state_o;

  muldiv_seq_ctrl #(.MAX_CYCLES(MAX_CYCLES)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_valid_i  (req_valid_i),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_ready_o  (req_ready_o),
    .stall_o      (stall_o),
    .res_o        (res_o),
    .res_valid_o  (res_valid_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .unit_start_o (unit_start_o),
    .unit_div_o   (unit_div_o),
    .unit_a_o     (unit_a_o),
    .unit_b_o     (unit_b_o),
    .unit_abort_o (unit_abort_o),
    .unit_done_i  (unit_done_i),
    .unit_hi_i    (unit_hi_i),
    .unit_lo_i    (unit_lo_i),
    .dbg_state_o  (dbg_state_o)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic        exp_to = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic reset_checks();
    chk("rst_res", res_o, 32'd0);
    chk_b("rst_rv", res_valid_o, 1'b0);
    chk_b("rst_start", unit_start_o, 1'b0);
    chk_b("rst_abort", unit_abort_o, 1'b0);
    chk_b("rst_busy", busy_o, 1'b0);
    chk_b("rst_to", timeout_o, 1'b0);
    chk_b("rst_div", unit_div_o, 1'b0);
    chk("rst_a", unit_a_o, 32'd0);
    chk("rst_b", unit_b_o, 32'd0);
  endtask

  // At a negedge with a request already driven and the DUT expected idle.
  task automatic idle_checks();
    chk_b("idle_rdy", req_ready_o, 1'b1);
    chk_b("idle_stall", stall_o, 1'b0);
    chk_b("idle_busy", busy_o, 1'b0);
    chk_b("idle_start", unit_start_o, 1'b0);
    chk_b("idle_abort", unit_abort_o, 1'b0);
    chk_b("idle_rv", res_valid_o, 1'b0);
    chk_b("idle_to", timeout_o, exp_to);
  endtask

  task automatic take_result(input string tag);
    logic [31:0] e;
    chk_b({tag, "_rv"}, res_valid_o, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_res"}, res_o, e);
    end
  endtask

  // driver tasks: all start and end at posedge+1
  task automatic do_read(input bit hi_sel);
    req_valid_i = 1'b1;
    req_op_i    = hi_sel ? 2'b11 : 2'b10;
    req_a_i     = $urandom;
    req_b_i     = $urandom;
    @(negedge clk_i);
    idle_checks();
    exp_q.push_back(hi_sel ? exp_hi : exp_lo);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    take_result(hi_sel ? "rd_hi" : "rd_lo");
    @(posedge clk_i); #1;
  endtask

  task automatic idle_noise();
    unit_done_i = 1'b1;
    unit_hi_i   = $urandom;
    unit_lo_i   = $urandom;
    @(negedge clk_i);
    chk_b("noise_busy", busy_o, 1'b0);
    chk_b("noise_rdy", req_ready_o, 1'b1);
    @(posedge clk_i); #1;
    unit_done_i = 1'b0;
  endtask

  // done_at: BUSY cycle index (0 = first) in which the unit reports done; -1 = never.
  task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                       input int done_at, input bit hold_read);
    logic [31:0] u_hi, u_lo;
    logic [63:0] prod;
    bit done_seen, fwd_taken;
    req_valid_i = 1'b1;
    req_op_i    = is_div ? 2'b01 : 2'b00;
    req_a_i     = a;
    req_b_i     = b;
    @(negedge clk_i);
    idle_checks();
    @(posedge clk_i); #1;
    if (is_div && b == 32'd0) begin
      req_valid_i = 1'b0;
      exp_hi = a;
      exp_lo = 32'hFFFF_FFFF;
      return;
    end
    if (is_div) begin
      u_lo = a / b;
      u_hi = a % b;
    end else begin
      prod = 64'(a) * 64'(b);
      u_hi = prod[63:32];
      u_lo = prod[31:0];
    end
    req_valid_i = hold_read;
    req_op_i    = 2'b10;
    req_a_i     = $urandom;
    req_b_i     = $urandom;
    unit_done_i = ($urandom_range(0, 2) == 0);
    unit_hi_i   = $urandom;
    unit_lo_i   = $urandom;
    @(negedge clk_i);
    chk_b("launch_start", unit_start_o, 1'b1);
    chk_b("launch_busy", busy_o, 1'b1);
    chk_b("launch_div", unit_div_o, is_div);
    chk("launch_a", unit_a_o, a);
    chk("launch_b", unit_b_o, b);
    chk_b("launch_rdy", req_ready_o, 1'b0);
    chk_b("launch_stall", stall_o, hold_read);
    @(posedge clk_i); #1;
    done_seen = 1'b0;
    for (int j = 0; j < MAX_CYCLES; j++) begin
      unit_done_i = (j == done_at);
      unit_hi_i   = (j == done_at) ? u_hi : $urandom;
      unit_lo_i   = (j == done_at) ? u_lo : $urandom;
      @(negedge clk_i);
      chk_b("busy_busy", busy_o, 1'b1);
      chk_b("busy_start", unit_start_o, 1'b0);
      chk_b("busy_abort", unit_abort_o, 1'b0);
      chk("busy_a_held", unit_a_o, a);
      chk_b("busy_stall", stall_o, hold_read && !(FWD && j == done_at));
      @(posedge clk_i); #1;
      if (j == done_at) begin
        done_seen = 1'b1;
        break;
      end
    end
    unit_done_i = 1'b0;
    fwd_taken = FWD && done_seen && hold_read;
    if (done_seen) begin
      exp_hi = u_hi;
      exp_lo = u_lo;
    end else begin
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      exp_to = 1'b1;
    end
    chk_b("end_busy", busy_o, 1'b0);
    chk_b("end_abort", unit_abort_o, !done_seen);
    chk_b("end_to", timeout_o, exp_to);
    if (fwd_taken) begin
      req_valid_i = 1'b0;
      exp_q.push_back(exp_lo);
      take_result("fwd");
    end else begin
      chk_b("end_rv", res_valid_o, 1'b0);
    end
    if (hold_read && !fwd_taken) begin
      @(negedge clk_i);
      chk_b("held_rdy", req_ready_o, 1'b1);
      chk_b("held_stall", stall_o, 1'b0);
      exp_q.push_back(exp_lo);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      take_result("held");
    end
    if (hold_read || !done_seen) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    int kind;
    int lat;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk_i);
    #1;
    reset_checks();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // MULT 7x6, done 33 cycles after start
    do_op(1'b0, 32'd7, 32'd6, 32, 1'b0);
    do_read(1'b0);
    do_read(1'b1);

    // reset in the middle of BUSY
    do_op(1'b0, 32'hDEAD_0001, 32'h0000_0010, 5, 1'b0);
    req_valid_i = 1'b1;
    req_op_i    = 2'b00;
    req_a_i     = 32'd5;
    req_b_i     = 32'd7;
    @(negedge clk_i);
    idle_checks();
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    #1 reset_checks();
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    exp_to = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    do_read(1'b0);
    do_read(1'b1);

    // divide by zero, read right after
    do_op(1'b1, 32'd100, 32'd0, 0, 1'b0);
    do_read(1'b1);
    do_read(1'b0);

    // done and expiry in the same cycle
    do_op(1'b1, 32'd9, 32'd3, MAX_CYCLES - 1, 1'b0);
    do_read(1'b0);

    // MFLO held during BUSY
    do_op(1'b0, 32'h0000_1234, 32'd1, 10, 1'b1);
    do_read(1'b1);

    // watchdog expiry
    do_op(1'b1, 32'd9, 32'd3, -1, 1'b0);
    do_read(1'b0);
    do_read(1'b1);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      ra   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      lat  = ($urandom_range(0, 9) == 0) ? -1 :
             (($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_CYCLES - 1) : $urandom_range(0, 5));
      case (kind)
        0: do_read(1'b0);
        1: do_read(1'b1);
        2: do_op(1'b0, ra, rb, lat, 1'($urandom_range(0, 1)));
        3: do_op(1'b1, ra, rb, lat, 1'($urandom_range(0, 1)));
        4: idle_noise();
        default: begin
          do_op(1'($urandom_range(0, 1)), ra, rb | 32'd1, lat, 1'b0);
          do_read(1'($urandom_range(0, 1)));
        end
      endcase
    end
    do_read(1'b0);
    do_read(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
